// File: rtl/soc_bus_initiator_pkg.sv
// Shared register-access types for the SoC bus initiator: command payload,
// initiator FSM states and the response record.
package soc_bus_initiator_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } reg_access_t;

  localparam int unsigned REG_ACCESS_W = $bits(reg_access_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
  } bus_rsp_t;

  // Byte address bits are not part of the word address on the bus.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/SoC_MemBus.sv
// Peripheral bus between the initiator and a fixed-latency register target.
interface SoC_MemBus;
  import soc_bus_initiator_pkg::*;

  logic              req;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic [DATA_W-1:0] rdata;

  modport Master (output req, write, addr, wdata, wmask, input rdata);
  modport Slave  (input req, write, addr, wdata, wmask, output rdata);

endinterface

// File: rtl/soc_cmd_fifo.sv
// Small synchronous command FIFO; a push on a full FIFO is taken when a pop
// happens in the same cycle.
module soc_cmd_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign wr_en     = push && (!full || pop);
  assign rd_en     = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : PTR_W'(wr_ptr_q + 1'b1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : PTR_W'(rd_ptr_q + 1'b1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/soc_bus_initiator.sv
// Command/response front end for the SoC peripheral bus: buffers commands,
// issues one access at a time and returns in-order responses with a watchdog.
module soc_bus_initiator
  import soc_bus_initiator_pkg::*;
#(
  parameter int unsigned BUS_LATENCY = 1,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [MASK_W-1:0] cmd_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  SoC_MemBus.Master         mem_bus
);

  localparam int unsigned      FIFO_DEPTH = 2;
  localparam logic [CNT_W-1:0] LAT_CNT    = CNT_W'(BUS_LATENCY);
  // A watchdog at or beyond the bus latency can never beat completion.
  localparam bit               TMO_EN     = (TIMEOUT > 0) && (TIMEOUT < BUS_LATENCY);
  localparam logic [CNT_W-1:0] TMO_CNT    = TMO_EN ? CNT_W'(TIMEOUT) : '0;

  bus_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cur_write_q, cur_write_d;
  bus_rsp_t                rsp_q, rsp_d;

  reg_access_t             cmd_entry;
  reg_access_t             head;
  logic [REG_ACCESS_W-1:0] head_raw;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop;
  logic                    lat_done, tmo_hit;

  assign cmd_entry = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wmask: cmd_wmask};
  assign head      = reg_access_t'(head_raw);
  assign pop       = (state_q == REQ);
  assign cmd_ready = !res && (!fifo_full || pop);
  assign push      = cmd_valid && cmd_ready;

  soc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REG_ACCESS_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (res),
    .push      (push),
    .push_data (cmd_entry),
    .pop       (pop),
    .head_data (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Single-cycle request straight from the FIFO head.
  assign mem_bus.req   = pop;
  assign mem_bus.write = pop && head.write;
  assign mem_bus.addr  = pop ? word_align(head.addr) : '0;
  assign mem_bus.wdata = pop ? head.wdata : '0;
  assign mem_bus.wmask = pop ? head.wmask : '0;

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_error = rsp_q.error;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_write_d = cur_write_q;
    rsp_d       = rsp_q;
    lat_done    = 1'b0;
    tmo_hit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = REQ;
      end
      REQ: begin
        cur_write_d = head.write;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        cnt_d    = CNT_W'(cnt_q + 1'b1);
        lat_done = (cnt_d == LAT_CNT);
        tmo_hit  = TMO_EN && (cnt_d == TMO_CNT);
        if (lat_done) begin
          rsp_d.rdata = cur_write_q ? '0 : mem_bus.rdata;
          rsp_d.error = 1'b0;
          state_d     = RESP;
        end else if (tmo_hit) begin
          rsp_d.rdata = '0;
          rsp_d.error = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_write_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_write_q <= cur_write_d;
      rsp_q       <= rsp_d;
    end
  end

endmodule
